mvm_engine: RTL and testbench

Parametrised matrix-vector multiply engine, successor to the fixed 8-bit load/ALU/read top. It streams in an optional N_OUT×N_IN signed coefficient matrix and an N_IN-element signed input vector, then computes N_OUT dot products with one MAC per cycle. Results leave through a valid/ready stream with per-word overflow flags. The block sits between the host byte-load interface and the result readout path, replacing the separate controller/logic pair with one parametrised unit.

---
 rtl/mvm_pkg.sv | 27 ++
 rtl/mvm_mac.sv | 44 ++++
 rtl/mvm_engine.sv | 186 ++++++++++++++++++
 tb/tb_mvm_engine.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared state encoding, default sizing and
// accumulator clamp limits for the matrix-vector engine.
package mvm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_N_IN     = 8;
    localparam int DEF_N_OUT    = 4;
    localparam int DEF_ACC_W    = 24;
    localparam bit DEF_SATURATE = 1'b1;

    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// mvm_mac: one signed multiply-accumulate step with a guard
// bit for overflow detection, clamp or wrap, and sticky flag.
module mvm_mac
    import mvm_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     ovf_in,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int EW = ACC_W + 1 - PW;

    localparam logic signed [ACC_W-1:0] MAX_V =
        ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V =
        ACC_W'(sat_min(ACC_W));

    logic signed [PW-1:0]  prod;
    logic signed [ACC_W:0] wide;
    logic                  hit;

    // Full-width product, one-bit-wider add, then clamp or wrap
    always_comb begin
        prod = $signed({{DATA_W{w[DATA_W-1]}}, w})
             * $signed({{DATA_W{x[DATA_W-1]}}, x});
        wide = $signed({acc[ACC_W-1], acc})
             + $signed({{EW{prod[PW-1]}}, prod});
        hit  = wide[ACC_W] ^ wide[ACC_W-1];
        sum  = wide[ACC_W-1:0];
        if (SATURATE && hit) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
        ovf = ovf_in | hit;
    end

endmodule

// File: rtl/mvm_engine.sv
// mvm_engine: streams in weights and a vector, runs one MAC
// per cycle, and returns N_OUT results over valid/ready.
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int N_IN     = DEF_N_IN,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int ACC_W    = DEF_ACC_W,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_w,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_last,
    output logic              busy,
    output logic              finish
);

    localparam int IW = $clog2(N_IN);
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

    state_t state, state_nx;

    logic [IW-1:0] i_cnt;
    logic [OW-1:0] o_cnt;
    logic [OW-1:0] k_cnt;
    logic [OW-1:0] k_nx;

    logic signed [DATA_W-1:0] w_mem [N_OUT][N_IN];
    logic signed [DATA_W-1:0] x_mem [N_IN];
    logic signed [ACC_W-1:0]  res   [N_OUT];
    logic [N_OUT-1:0]         ovf_buf;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_in;
    logic signed [ACC_W-1:0] mac_sum;
    logic                    acc_ovf;
    logic                    ovf_in;
    logic                    mac_ovf;

    logic in_fire, out_fire;
    logic i_last, o_last, k_last, mac_done;

    assign in_ready = (state == S_LOAD_W) || (state == S_LOAD_X);
    assign busy     = (state != S_IDLE);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign i_last   = (i_cnt == I_LAST);
    assign o_last   = (o_cnt == O_LAST);
    assign k_last   = (k_cnt == O_LAST);
    assign k_nx     = k_cnt + 1'b1;
    assign mac_done = (state == S_COMPUTE) && i_last && o_last;
    assign acc_in   = (i_cnt == '0) ? '0 : acc;
    assign ovf_in   = (i_cnt == '0) ? 1'b0 : acc_ovf;

    mvm_mac #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
    ) u_mac (
        .w     (w_mem[o_cnt][i_cnt]),
        .x     (x_mem[i_cnt]),
        .acc   (acc_in),
        .ovf_in(ovf_in),
        .sum   (mac_sum),
        .ovf   (mac_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = load_w ? S_LOAD_W : S_LOAD_X;
            end
            S_LOAD_W: begin
                if (in_fire && i_last && o_last) state_nx = S_LOAD_X;
            end
            S_LOAD_X: begin
                if (in_fire && i_last) state_nx = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (i_last && o_last) state_nx = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_fire && k_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Load indexing, operand storage and the MAC loop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt   <= '0;
            o_cnt   <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            ovf_buf <= '0;
            for (int o = 0; o < N_OUT; o++) begin
                res[o] <= '0;
                for (int i = 0; i < N_IN; i++) w_mem[o][i] <= '0;
            end
            for (int i = 0; i < N_IN; i++) x_mem[i] <= '0;
        end else begin
            unique case (state)
                S_LOAD_W: begin
                    if (in_fire) begin
                        w_mem[o_cnt][i_cnt] <= in_data;
                        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                        if (i_last) o_cnt <= o_last ? '0 : o_cnt + 1'b1;
                    end
                end
                S_LOAD_X: begin
                    if (in_fire) begin
                        x_mem[i_cnt] <= in_data;
                        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    acc     <= mac_sum;
                    acc_ovf <= mac_ovf;
                    i_cnt   <= i_last ? '0 : i_cnt + 1'b1;
                    if (i_last) begin
                        res[o_cnt]     <= mac_sum;
                        ovf_buf[o_cnt] <= mac_ovf;
                        o_cnt <= o_last ? '0 : o_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered result stream; the first word bypasses res
    // when the engine has a single output row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_last  <= 1'b0;
            finish    <= 1'b0;
            k_cnt     <= '0;
        end else begin
            finish <= 1'b0;
            if (mac_done) begin
                out_valid <= 1'b1;
                out_data  <= (o_cnt == '0) ? mac_sum : res[0];
                out_ovf   <= (o_cnt == '0) ? mac_ovf : ovf_buf[0];
                out_last  <= (N_OUT == 1);
                k_cnt     <= '0;
            end else if (state == S_OUTPUT && out_fire) begin
                if (k_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    finish    <= 1'b1;
                    k_cnt     <= '0;
                end else begin
                    out_data <= res[k_nx];
                    out_ovf  <= ovf_buf[k_nx];
                    out_last <= (k_nx == O_LAST);
                    k_cnt    <= k_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_engine.sv
// tb_mvm_engine: scoreboard bench for three engine builds
// (24-bit saturating, 16-bit saturating, 16-bit wrapping).
module tb_mvm_engine;

    localparam int NI = 8;
    localparam int NO = 4;

    typedef struct packed {
        logic signed [63:0] data;
        logic               ovf;
        logic               last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       load_w = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    logic        in_ready, out_valid, out_ovf, out_last;
    logic        busy, finish;
    logic [23:0] out_data;

    logic        in_ready_s, out_valid_s, out_ovf_s, out_last_s;
    logic        busy_s, finish_s;
    logic [15:0] out_data_s;

    logic        in_ready_w, out_valid_w, out_ovf_w, out_last_w;
    logic        busy_w, finish_w;
    logic [15:0] out_data_w;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    longint mw [NO][NI];
    longint xv [NI];
    longint wbuf [NO*NI];

    always #5 clk = ~clk;

    mvm_engine dut (
        .clk(clk), .rst(rst), .start(start), .load_w(load_w),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_last(out_last),
        .busy(busy), .finish(finish)
    );

    mvm_engine #(.ACC_W(16), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .load_w(load_w),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .out_last(out_last_s),
        .busy(busy_s), .finish(finish_s)
    );

    mvm_engine #(.ACC_W(16), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .load_w(load_w),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w),
        .out_ovf(out_ovf_w), .out_last(out_last_w),
        .busy(busy_w), .finish(finish_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_dot(
        input int o, input int accw, input bit sat,
        output longint r, output logic ov);
        longint hi, lo, acc, s, m;
        hi  = (longint'(1) <<< (accw - 1)) - 1;
        lo  = -hi - 1;
        m   = longint'(1) <<< accw;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            s = acc + mw[o][i] * xv[i];
            if (s > hi || s < lo) begin
                ov = 1'b1;
                if (sat) begin
                    s = (s > hi) ? hi : lo;
                end else begin
                    s = s & (m - 1);
                    if (s > hi) s = s - m;
                end
            end
            acc = s;
        end
        r = acc;
    endfunction

    task automatic push_expected();
        longint r;
        logic   ov;
        logic   lst;
        for (int o = 0; o < NO; o++) begin
            lst = (o == NO - 1);
            model_dot(o, 24, 1'b1, r, ov);
            q0.push_back('{data: r, ovf: ov, last: lst});
            model_dot(o, 16, 1'b1, r, ov);
            q1.push_back('{data: r, ovf: ov, last: lst});
            model_dot(o, 16, 1'b0, r, ov);
            q2.push_back('{data: r, ovf: ov, last: lst});
        end
    endtask

    task automatic start_job(input logic lw);
        start  = 1'b1;
        load_w = lw;
        step();
        start  = 1'b0;
        load_w = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL start_accept busy=%b in_ready=%b want 1/1",
                     busy, in_ready);
        else n_pass++;
    endtask

    task automatic send_w(input bit gaps);
        int t;
        for (int j = 0; j < NO*NI; j++) begin
            mw[j / NI][j % NI] = wbuf[j];
            if (gaps && (j % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
                step();
            end
            in_valid = 1'b1;
            in_data  = wbuf[j][7:0];
            t = 0;
            while (!in_ready && t < 20) begin step(); t++; end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_x(input bit gaps);
        int t;
        for (int j = 0; j < NI; j++) begin
            if (gaps && (j % 2 == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = xv[j][7:0];
            t = 0;
            while (!in_ready && t < 20) begin step(); t++; end
            if (t >= 20) begin
                n_checks++;
                $display("FAIL in_ready_timeout word=%0d", j);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_k, input int stall_n,
                           input int exp_cyc, input int exp_lat);
        int   k = 0;
        int   stalled = 0;
        int   cyc = 0;
        int   t = 0;
        int   lat = -1;
        bit   done = 1'b0;
        exp_t e0, e1, e2;
        while (!done && t < 400) begin
            out_ready = !(k == stall_k && stalled < stall_n);
            if (out_valid) begin
                if (lat < 0) lat = t;
                cyc++;
                if (q0.size() == 0 || q1.size() == 0 ||
                    q2.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty k=%0d", k);
                    done = 1'b1;
                end else begin
                    e0 = q0[0];
                    e1 = q1[0];
                    e2 = q2[0];
                    n_checks++;
                    if (longint'($signed(out_data)) !== e0.data)
                        $display("FAIL data24 k=%0d got %0d want %0d",
                                 k, $signed(out_data), e0.data);
                    else n_pass++;
                    n_checks++;
                    if (out_ovf !== e0.ovf || out_last !== e0.last)
                        $display("FAIL flags24 k=%0d ovf=%b last=%b want %b/%b",
                                 k, out_ovf, out_last, e0.ovf, e0.last);
                    else n_pass++;
                    n_checks++;
                    if (longint'($signed(out_data_s)) !== e1.data ||
                        out_ovf_s !== e1.ovf || !out_valid_s)
                        $display("FAIL sat16 k=%0d got %0d/%b want %0d/%b",
                                 k, $signed(out_data_s), out_ovf_s,
                                 e1.data, e1.ovf);
                    else n_pass++;
                    n_checks++;
                    if (longint'($signed(out_data_w)) !== e2.data ||
                        out_ovf_w !== e2.ovf || !out_valid_w)
                        $display("FAIL wrap16 k=%0d got %0d/%b want %0d/%b",
                                 k, $signed(out_data_w), out_ovf_w,
                                 e2.data, e2.ovf);
                    else n_pass++;
                    if (out_ready) begin
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                        void'(q2.pop_front());
                        k++;
                        if (k == NO) done = 1'b1;
                    end else begin
                        stalled++;
                    end
                end
            end
            step();
            t++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (!done) $display("FAIL output_timeout k=%0d want %0d", k, NO);
        else n_pass++;
        n_checks++;
        if (cyc !== exp_cyc)
            $display("FAIL output_cycles got %0d want %0d", cyc, exp_cyc);
        else n_pass++;
        if (exp_lat >= 0) begin
            n_checks++;
            if (lat !== exp_lat)
                $display("FAIL latency got %0d want %0d", lat, exp_lat);
            else n_pass++;
        end
        n_checks++;
        if (finish !== 1'b1 || busy !== 1'b0)
            $display("FAIL finish_pulse finish=%b busy=%b want 1/0",
                     finish, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if ({in_ready, out_valid, out_ovf, out_last, busy, finish} !== 6'b0
            || out_data !== 24'd0)
            $display("FAIL reset_outputs got %b/%0d want 0/0",
                     {in_ready, out_valid, out_ovf, out_last, busy, finish},
                     out_data);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL idle_after_reset busy=%b in_ready=%b want 0/0",
                     busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_ones();
        for (int j = 0; j < NO*NI; j++) wbuf[j] = 1;
        for (int i = 0; i < NI; i++) xv[i] = i + 1;
        start_job(1'b1);
        send_w(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
        n_checks++;
        if (finish !== 1'b0)
            $display("FAIL finish_single got %b want 0", finish);
        else n_pass++;
    endtask

    task automatic test_retain();
        for (int j = 0; j < NO*NI; j++) wbuf[j] = j / NI + 1;
        for (int i = 0; i < NI; i++) xv[i] = 1;
        start_job(1'b1);
        send_w(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
        for (int i = 0; i < NI; i++) xv[i] = 2;
        start_job(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
    endtask

    task automatic test_signed();
        for (int j = 0; j < NO*NI; j++) wbuf[j] = -128;
        for (int i = 0; i < NI; i++) xv[i] = -128;
        start_job(1'b1);
        send_w(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
    endtask

    task automatic test_stall();
        for (int i = 0; i < NI; i++) xv[i] = 3 - i;
        start_job(1'b0);
        push_expected();
        send_x(1'b0);
        collect(1, 5, NO + 5, NO*NI);
        step();
    endtask

    task automatic test_ignore();
        for (int j = 0; j < NO*NI; j++) wbuf[j] = (j % 7) - 3;
        for (int i = 0; i < NI; i++) xv[i] = 5 * i - 17;
        start_job(1'b1);
        send_w(1'b1);
        push_expected();
        send_x(1'b1);
        step();
        step();
        start    = 1'b1;
        load_w   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h7f;
        step();
        step();
        start    = 1'b0;
        load_w   = 1'b0;
        in_valid = 1'b0;
        collect(-1, 0, NO, NO*NI - 4);
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NI; i++) xv[i] = -i;
        start_job(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        for (int i = 0; i < NI; i++) xv[i] = i * 3;
        start_job(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NI; i++) xv[i] = 9;
        start_job(1'b0);
        send_x(1'b0);
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_ovf, out_last, busy, finish} !== 6'b0
            || out_data !== 24'd0)
            $display("FAIL reset_mid got %b/%0d want 0/0",
                     {in_ready, out_valid, out_ovf, out_last, busy, finish},
                     out_data);
        else n_pass++;
        step();
        rst = 1'b1;
        for (int o = 0; o < NO; o++)
            for (int i = 0; i < NI; i++) mw[o][i] = 0;
        step();
        for (int i = 0; i < NI; i++) xv[i] = i + 1;
        start_job(1'b0);
        push_expected();
        send_x(1'b0);
        collect(-1, 0, NO, NO*NI);
        step();
    endtask

    initial begin
        for (int o = 0; o < NO; o++)
            for (int i = 0; i < NI; i++) mw[o][i] = 0;
        test_reset();
        test_ones();
        test_retain();
        test_signed();
        test_stall();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
